bin_pool_2x2: RTL and testbench
===============================

Name: bin_pool_2x2

Overview:
- Downstream stage of the binary 3x3 XNOR-convolution engine.
- Reads the binary feature maps that stage writes and applies 2x2, stride-2 OR-pooling (binary max-pool).
- Writes the pooled maps to a separate output SRAM.
- Uses the same run/busy control style and the same registered-SRAM interface style as the convolution stage.

Parameters:
ADDR_W, 12, width of both SRAM address buses
DATA_W, 16, SRAM word width; also the maximum map dimension
TERM_WORD, 16'h00FF, header value that ends the run

Ports:
clk  input  1  clock; all flops on the rising edge
reset_b  input  1  asynchronous active-low reset
pool_run  input  1  start pulse; sampled only in IDLE
pool_busy  output  1  high while a run is in progress
pool_sram_read_address  output  ADDR_W  input-SRAM read address
sram_pool_read_data  input  DATA_W  input-SRAM read data; valid 1 cycle after the address
pool_sram_write_address  output  ADDR_W  output-SRAM write address
pool_sram_write_data  output  DATA_W  output-SRAM write data
pool_sram_write_enable  output  1  output-SRAM write strobe; one word written per cycle it is high

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, all internal counters are 0. Reset asserted mid-run aborts immediately; no further writes occur. After reset release the block waits in IDLE for a new pool_run.
- Input format, starting at address 0:
  - A header word whose bits [4:0] give D.
  - Then D row words. Bit c of a row word is pixel column c; only bits [D-1:0] are meaningful.
  - Images follow back-to-back.
  - A header equal to TERM_WORD, or any header that is not an even D in 2..16, ends the run.
- Output format, starting at address 0:
  - For each image: a header word D/2, then D/2 pooled rows.
  - The run ends with exactly one TERM_WORD write.
  - Write addresses are contiguous, increasing by 1 per write.
- Pooling rule: output row r, bit j = in[2r][2j] | in[2r][2j+1] | in[2r+1][2j] | in[2r+1][2j+1], for j < D/2. Bits [15:D/2] are 0.
- FSM states:
  - IDLE: busy=0, read_address held at 0. pool_run=1 -> HDR.
  - HDR: await header data. Valid header: latch D, write header D/2 -> ROW_A. Invalid header or TERM_WORD -> TERM.
  - ROW_A: capture the even row.
  - ROW_B: capture the odd row; the pooled word is written on the following cycle. Row pairs remaining -> ROW_A. Last pair done -> HDR, with the read address already pointing at the next header.
  - TERM: write TERM_WORD -> DONE.
  - DONE: busy falls on the next edge -> IDLE.
- Read addressing: the read address advances by 1 each cycle a word is consumed. The 1-cycle read latency is absorbed by issuing the next address while the current word returns; no word is read twice.
- pool_busy: rises on the edge after pool_run is sampled in IDLE; falls on the edge after the TERM_WORD write. pool_run while busy is ignored.
- pool_sram_write_enable is a single-cycle strobe per word, never high in IDLE. Write address and data are stable in the cycle the strobe is high.
- Throughput bound: total cycles from the pool_run sample to pool_busy falling must be at most (words read) + (words written) + 4.
- Address counters do not wrap within a legal run; the block performs no overflow checking beyond ADDR_W.

Test Plan:
- Single image D=4, rows 0x0001, 0x0000, 0x0000, 0x0008, then 0x00FF -> writes 0x0002, 0x0001, 0x0002, 0x00FF at addresses 0..3; busy falls within 13 cycles.
- D=16, all rows 0xFFFF, then terminator -> 8 rows of 0x00FF after header 0x0008, then 0x00FF; 10 writes total.
- Back-to-back images D=10 (rows alternating 0x0155/0x0000) then D=14 (all 0x0000), then terminator -> 0x0005, five 0x001F, 0x0007, seven 0x0000, 0x00FF.
- First header 0x00FF -> only 0x00FF written at address 0; busy high for 3 cycles or fewer.
- Header 0x0007 (odd) -> treated as terminator: only TERM_WORD written; row data ignored.
- reset_b pulsed low mid-image -> all outputs 0 at once; subsequent pool_run restarts from read and write address 0. A pool_run pulse while busy -> no effect on the output sequence.

Source files
------------

// File: rtl/bin_pool_2x2.sv
// bin_pool_2x2
//   2x2, stride-2 OR-pooling (binary max-pool) over the binary feature maps
//   written by the XNOR-convolution stage. Reads images from the input SRAM
//   starting at address 0. Each image is a header word holding D, followed by
//   D row words. It writes the pooled images (header D/2, then D/2 rows) to
//   the output SRAM starting at address 0. A terminator or any invalid header
//   ends the run with a single TERM_WORD write.
//
// Ports
//   clk                      rising-edge clock
//   reset_b                  asynchronous active-low reset
//   pool_run                 start pulse, sampled only while idle
//   pool_busy                high while a run is in progress
//   pool_sram_read_address   input-SRAM read address (data returns 1 cycle later)
//   sram_pool_read_data      input-SRAM read data
//   pool_sram_write_address  output-SRAM write address
//   pool_sram_write_data     output-SRAM write data
//   pool_sram_write_enable   output-SRAM write strobe, one word per high cycle
module bin_pool_2x2 #(
  parameter int                 ADDR_W    = 12,
  parameter int                 DATA_W    = 16,
  parameter logic [DATA_W-1:0]  TERM_WORD = 16'h00FF
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              pool_run,
  output logic              pool_busy,
  output logic [ADDR_W-1:0] pool_sram_read_address,
  input  logic [DATA_W-1:0] sram_pool_read_data,
  output logic [ADDR_W-1:0] pool_sram_write_address,
  output logic [DATA_W-1:0] pool_sram_write_data,
  output logic              pool_sram_write_enable
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HDR   = 3'd1;
  localparam logic [2:0] ROW_A = 3'd2;
  localparam logic [2:0] ROW_B = 3'd3;
  localparam logic [2:0] TERM  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]        state_q,   state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q,   wr_en_d;
  logic              busy_q,    busy_d;
  logic [3:0]        half_q,    half_d;
  logic [3:0]        pairs_q,   pairs_d;
  logic [DATA_W-1:0] row_a_q,   row_a_d;

  logic [4:0]        hdr_dim;
  logic              hdr_ok;
  logic [DATA_W-1:0] pooled;

  assign hdr_dim = sram_pool_read_data[4:0];
  assign hdr_ok  = (sram_pool_read_data != TERM_WORD) && !hdr_dim[0] &&
                   (hdr_dim >= 5'd2) && (hdr_dim <= 5'd16);

  // Columns at or beyond D carry no meaning, so output bits j >= D/2 are forced to 0.
  always_comb begin
    pooled = '0;
    for (int unsigned j = 0; j < DATA_W / 2; j++) begin
      pooled[j] = (j < 32'(half_q)) &
                  (row_a_q[2*j] | row_a_q[2*j+1] |
                   sram_pool_read_data[2*j] | sram_pool_read_data[2*j+1]);
    end
  end

  // The read address always runs one word ahead of the word being consumed,
  // which hides the 1-cycle SRAM latency: leaving IDLE already issues address 1
  // while the header at address 0 returns.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q + ADDR_W'(wr_en_q);
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    half_d    = half_q;
    pairs_d   = pairs_q;
    row_a_d   = row_a_q;
    case (state_q)
      IDLE: begin
        rd_addr_d = '0;
        wr_addr_d = '0;
        if (pool_run) begin
          state_d   = HDR;
          rd_addr_d = ADDR_W'(1);
        end
      end
      HDR: begin
        if (hdr_ok) begin
          half_d    = hdr_dim[4:1];
          pairs_d   = hdr_dim[4:1];
          wr_en_d   = 1'b1;
          wr_data_d = DATA_W'(hdr_dim[4:1]);
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          state_d   = ROW_A;
        end else begin
          state_d = TERM;
        end
      end
      ROW_A: begin
        row_a_d   = sram_pool_read_data;
        rd_addr_d = rd_addr_q + ADDR_W'(1);
        state_d   = ROW_B;
      end
      ROW_B: begin
        wr_en_d   = 1'b1;
        wr_data_d = pooled;
        rd_addr_d = rd_addr_q + ADDR_W'(1);
        pairs_d   = pairs_q - 4'd1;
        state_d   = (pairs_q == 4'd1) ? HDR : ROW_A;
      end
      TERM: begin
        wr_en_d   = 1'b1;
        wr_data_d = TERM_WORD;
        rd_addr_d = '0;
        state_d   = DONE;
      end
      DONE: begin
        rd_addr_d = '0;
        wr_addr_d = '0;
        state_d   = IDLE;
      end
      default: begin
        rd_addr_d = '0;
        wr_addr_d = '0;
        state_d   = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      half_q    <= '0;
      pairs_q   <= '0;
      row_a_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      half_q    <= half_d;
      pairs_q   <= pairs_d;
      row_a_q   <= row_a_d;
    end
  end

  assign pool_busy               = busy_q;
  assign pool_sram_read_address  = rd_addr_q;
  assign pool_sram_write_address = wr_addr_q;
  assign pool_sram_write_data    = wr_data_q;
  assign pool_sram_write_enable  = wr_en_q;

endmodule

// File: tb/tb_bin_pool_2x2.sv
// tb_bin_pool_2x2
//   Directed bench for bin_pool_2x2: a small input-SRAM model with 1-cycle
//   read latency, write capture on the falling edge, and hand-computed
//   expected output sequences.
module tb_bin_pool_2x2;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        pool_run;
  logic        pool_busy;
  logic [11:0] rd_addr;
  logic [15:0] rd_data;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_en;

  logic [15:0] mem [0:63];
  logic [15:0] exp_q [$];
  logic [15:0] obs_d [$];
  logic [11:0] obs_a [$];
  int          checks   = 0;
  int          failures = 0;
  int          cycles;

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr[5:0]];

  bin_pool_2x2 #(.ADDR_W(12), .DATA_W(16), .TERM_WORD(16'h00FF)) dut (
    .clk                     (clk),
    .reset_b                 (reset_b),
    .pool_run                (pool_run),
    .pool_busy               (pool_busy),
    .pool_sram_read_address  (rd_addr),
    .sram_pool_read_data     (rd_data),
    .pool_sram_write_address (wr_addr),
    .pool_sram_write_data    (wr_data),
    .pool_sram_write_enable  (wr_en)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_le(input string tag, input int obs, input int lim);
    checks++;
    assert (obs <= lim) else begin
      failures++;
      $error("FAIL %s observed=%0d expected<=%0d", tag, obs, lim);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
  endtask

  // Pulse pool_run, then follow the run on falling edges until busy drops,
  // logging every write. glitch_at >= 0 re-asserts pool_run mid-run.
  task automatic run(input int budget, input int glitch_at, output int n);
    obs_d.delete();
    obs_a.delete();
    @(negedge clk);
    pool_run = 1'b1;
    @(negedge clk);
    pool_run = 1'b0;
    n = 0;
    while (pool_busy && n < budget) begin
      if (wr_en) begin
        obs_d.push_back(wr_data);
        obs_a.push_back(wr_addr);
      end
      n++;
      pool_run = (n == glitch_at);
      @(negedge clk);
    end
    pool_run = 1'b0;
    chk("busy_fell", {31'd0, pool_busy}, 32'd0);
    chk("idle_no_write", {31'd0, wr_en}, 32'd0);
    chk("idle_rd_addr", {20'd0, rd_addr}, 32'd0);
  endtask

  task automatic check_writes(input string tag);
    chk($sformatf("%s write_count", tag), obs_d.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_d.size(); i++) begin
      chk($sformatf("%s addr[%0d]", tag, i), {20'd0, obs_a[i]}, i);
      chk($sformatf("%s data[%0d]", tag, i), {16'd0, obs_d[i]}, {16'd0, exp_q[i]});
    end
  endtask

  task automatic load_t3();
    clear_mem();
    mem[0] = 16'd10;
    for (int i = 0; i < 10; i++) mem[1+i] = (i % 2 == 0) ? 16'h0155 : 16'h0000;
    mem[11] = 16'd14;
    mem[26] = 16'h00FF;
    exp_q = {16'h0005, 16'h001F, 16'h001F, 16'h001F, 16'h001F, 16'h001F,
             16'h0007, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
             16'h0000, 16'h0000, 16'h00FF};
  endtask

  initial begin
    reset_b  = 1'b0;
    pool_run = 1'b0;
    clear_mem();
    @(negedge clk);
    @(negedge clk);
    chk("rst busy",    {31'd0, pool_busy}, 32'd0);
    chk("rst we",      {31'd0, wr_en},     32'd0);
    chk("rst rd_addr", {20'd0, rd_addr},   32'd0);
    chk("rst wr_addr", {20'd0, wr_addr},   32'd0);
    chk("rst wr_data", {16'd0, wr_data},   32'd0);
    reset_b = 1'b1;
    @(negedge clk);

    // Single D=4 image
    clear_mem();
    mem[0] = 16'd4; mem[1] = 16'h0001; mem[4] = 16'h0008; mem[5] = 16'h00FF;
    exp_q = {16'h0002, 16'h0001, 16'h0002, 16'h00FF};
    run(100, -1, cycles);
    check_writes("d4");
    chk_le("d4 cycles", cycles, 13);

    // D=2 with columns beyond D set: they must not leak into the output
    clear_mem();
    mem[0] = 16'd2; mem[1] = 16'hFFFE; mem[2] = 16'hFFFF; mem[3] = 16'h00FF;
    exp_q = {16'h0001, 16'h0001, 16'h00FF};
    run(100, -1, cycles);
    check_writes("d2");
    chk_le("d2 cycles", cycles, 4 + 3 + 4);

    // D=16 all ones
    clear_mem();
    mem[0] = 16'd16;
    for (int i = 1; i <= 16; i++) mem[i] = 16'hFFFF;
    mem[17] = 16'h00FF;
    exp_q = {16'h0008, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF,
             16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF};
    run(100, -1, cycles);
    check_writes("d16");
    chk_le("d16 cycles", cycles, 18 + 10 + 4);

    // Back-to-back D=10 then D=14
    load_t3();
    run(200, -1, cycles);
    check_writes("d10d14");
    chk_le("d10d14 cycles", cycles, 27 + 15 + 4);

    // Immediate terminator
    clear_mem();
    mem[0] = 16'h00FF;
    exp_q = {16'h00FF};
    run(100, -1, cycles);
    check_writes("term");
    chk_le("term cycles", cycles, 3);

    // Odd header acts as terminator; row data ignored
    clear_mem();
    mem[0] = 16'h0007; mem[1] = 16'hFFFF; mem[2] = 16'hFFFF;
    exp_q = {16'h00FF};
    run(100, -1, cycles);
    check_writes("odd");

    // D=18 (even but too large) also terminates
    clear_mem();
    mem[0] = 16'd18; mem[1] = 16'hFFFF;
    exp_q = {16'h00FF};
    run(100, -1, cycles);
    check_writes("d18");

    // pool_run pulse while busy has no effect
    clear_mem();
    mem[0] = 16'd4; mem[1] = 16'h0001; mem[4] = 16'h0008; mem[5] = 16'h00FF;
    exp_q = {16'h0002, 16'h0001, 16'h0002, 16'h00FF};
    run(100, 3, cycles);
    check_writes("glitch");

    // Reset mid-image, then a clean restart from address 0
    load_t3();
    @(negedge clk);
    pool_run = 1'b1;
    @(negedge clk);
    pool_run = 1'b0;
    repeat (5) @(negedge clk);
    reset_b = 1'b0;
    #1;
    chk("midrst busy",    {31'd0, pool_busy}, 32'd0);
    chk("midrst we",      {31'd0, wr_en},     32'd0);
    chk("midrst rd_addr", {20'd0, rd_addr},   32'd0);
    chk("midrst wr_addr", {20'd0, wr_addr},   32'd0);
    chk("midrst wr_data", {16'd0, wr_data},   32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    chk("postrst busy", {31'd0, pool_busy}, 32'd0);
    run(200, -1, cycles);
    check_writes("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
